// File: rtl/l2_param_array.sv
// Dual-read, single-write L2 storage array with byte-masked writes, per-entry valid bits and a clear sweep.
// Optional registered read ports are enabled by defining L2_PARAM_ARRAY_REG_READ_EN.
module l2_param_array #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    output logic               busy,
    input  logic               write,
    input  logic [IDX_W-1:0]   windex,
    input  logic [WIDTH/8-1:0] wmask,
    input  logic [WIDTH-1:0]   datain,
    input  logic [IDX_W-1:0]   rindex_a,
    input  logic [IDX_W-1:0]   rindex_b,
    output logic [WIDTH-1:0]   dataout_a,
    output logic [WIDTH-1:0]   dataout_b,
    output logic               valid_a,
    output logic               valid_b
);

    localparam int NB = WIDTH / 8;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic             kill;
    logic             wr_en;

    function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_d,
                                                     input logic [WIDTH-1:0] new_d,
                                                     input logic [NB-1:0]    m);
        logic [WIDTH-1:0] r;
        r = old_d;
        for (int k = 0; k < NB; k++) begin
            if (m[k]) r[8*k +: 8] = new_d[8*k +: 8];
        end
        return r;
    endfunction

    assign kill  = reset | clear;
    assign busy  = (state_q == SWEEP);
    // A zero mask is treated as no write at all, so it cannot set the valid bit.
    assign wr_en = write && !busy && !kill && (wmask != '0);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (kill) begin
            state_d = SWEEP;
            ptr_d   = '0;
        end else if (state_q == SWEEP) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == IDX_W'(DEPTH - 1)) state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        ptr_q   <= ptr_d;
    end

    always_ff @(posedge clk) begin
        if (busy) begin
            mem[ptr_q] <= '0;
        end else if (wr_en) begin
            mem[windex] <= merge_bytes(mem[windex], datain, wmask);
        end
    end

    // Valid bits drop at once so unswept entries already read as empty.
    always_ff @(posedge clk) begin
        if (kill) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[windex] <= 1'b1;
        end
    end

`ifdef L2_PARAM_ARRAY_REG_READ_EN
    always_ff @(posedge clk) begin
        if (kill) begin
            dataout_a <= '0;
            valid_a   <= 1'b0;
            dataout_b <= '0;
            valid_b   <= 1'b0;
        end else begin
            if (wr_en && windex == rindex_a) begin
                dataout_a <= merge_bytes(mem[rindex_a], datain, wmask);
                valid_a   <= 1'b1;
            end else begin
                dataout_a <= valid_q[rindex_a] ? mem[rindex_a] : '0;
                valid_a   <= valid_q[rindex_a];
            end
            if (wr_en && windex == rindex_b) begin
                dataout_b <= merge_bytes(mem[rindex_b], datain, wmask);
                valid_b   <= 1'b1;
            end else begin
                dataout_b <= valid_q[rindex_b] ? mem[rindex_b] : '0;
                valid_b   <= valid_q[rindex_b];
            end
        end
    end
`else
    assign valid_a   = valid_q[rindex_a];
    assign valid_b   = valid_q[rindex_b];
    assign dataout_a = valid_q[rindex_a] ? mem[rindex_a] : '0;
    assign dataout_b = valid_q[rindex_b] ? mem[rindex_b] : '0;
`endif

endmodule

// File: tb/tb_l2_param_array.sv
// Directed bench for l2_param_array: reset sweep, masked/dual reads, dropped writes, clear restart.
module tb_l2_param_array;

    localparam int WIDTH = 128;
    localparam int DEPTH = 16;
    localparam int IDX_W = 4;

    logic               clk;
    logic               reset;
    logic               clear;
    logic               busy;
    logic               write;
    logic [IDX_W-1:0]   windex;
    logic [WIDTH/8-1:0] wmask;
    logic [WIDTH-1:0]   datain;
    logic [IDX_W-1:0]   rindex_a;
    logic [IDX_W-1:0]   rindex_b;
    logic [WIDTH-1:0]   dataout_a;
    logic [WIDTH-1:0]   dataout_b;
    logic               valid_a;
    logic               valid_b;

    int checks = 0;
    int errors = 0;
    int n;

    l2_param_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .busy      (busy),
        .write     (write),
        .windex    (windex),
        .wmask     (wmask),
        .datain    (datain),
        .rindex_a  (rindex_a),
        .rindex_b  (rindex_b),
        .dataout_a (dataout_a),
        .dataout_b (dataout_b),
        .valid_a   (valid_a),
        .valid_b   (valid_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [IDX_W-1:0] idx, input logic [WIDTH-1:0] d,
                            input logic [WIDTH/8-1:0] m);
        write  = 1'b1;
        windex = idx;
        datain = d;
        wmask  = m;
        tick();
        write  = 1'b0;
    endtask

    // Registered build sees the new index one edge later.
    task automatic read_check(input string tag, input logic [IDX_W-1:0] ra, input logic [IDX_W-1:0] rb,
                              input logic [WIDTH-1:0] ea, input logic va,
                              input logic [WIDTH-1:0] eb, input logic vb);
        rindex_a = ra;
        rindex_b = rb;
`ifdef L2_PARAM_ARRAY_REG_READ_EN
        tick();
`else
        #1;
`endif
        chk({tag, "_data_a"},  dataout_a, ea);
        chk({tag, "_valid_a"}, WIDTH'(valid_a), WIDTH'(va));
        chk({tag, "_data_b"},  dataout_b, eb);
        chk({tag, "_valid_b"}, WIDTH'(valid_b), WIDTH'(vb));
    endtask

    // Counts busy cycles from now, reading every index as empty along the way.
    task automatic count_busy(input string tag, output int cnt);
        cnt = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            cnt++;
            rindex_a = IDX_W'(i);
            rindex_b = IDX_W'(15 - (i % 16));
            #1;
            chk({tag, "_sweep_valid_a"}, WIDTH'(valid_a), '0);
            chk({tag, "_sweep_data_b"},  dataout_b, '0);
            tick();
        end
    endtask

    initial begin
        reset    = 1'b1;
        clear    = 1'b0;
        write    = 1'b0;
        windex   = '0;
        wmask    = '0;
        datain   = '0;
        rindex_a = '0;
        rindex_b = '0;

        // Reset held for three edges
        tick();
        chk("reset_busy", WIDTH'(busy), WIDTH'(1'b1));
        chk("reset_valid_a", WIDTH'(valid_a), '0);
        chk("reset_data_a", dataout_a, '0);
        chk("reset_data_b", dataout_b, '0);
        tick();
        tick();
        reset = 1'b0;
        count_busy("reset", n);
        chk("reset_sweep_len", WIDTH'(n), WIDTH'(16));
        chk("reset_busy_low", WIDTH'(busy), '0);

        // Masked write: full AA then low byte 55
        do_write(4'd5, {16{8'hAA}}, 16'hFFFF);
        do_write(4'd5, {16{8'h55}}, 16'h0001);
        read_check("masked", 4'd5, 4'd5, {{15{8'hAA}}, 8'h55}, 1'b1, {{15{8'hAA}}, 8'h55}, 1'b1);

        // Dual read
        do_write(4'd3, {16{8'h11}}, 16'hFFFF);
        do_write(4'd12, {16{8'h22}}, 16'hFFFF);
        read_check("dual", 4'd3, 4'd12, {16{8'h11}}, 1'b1, {16{8'h22}}, 1'b1);
        read_check("same_idx", 4'd12, 4'd12, {16{8'h22}}, 1'b1, {16{8'h22}}, 1'b1);

        // Zero mask: new entry stays invalid, existing entry unchanged
        do_write(4'd2, {16{8'hFF}}, 16'h0000);
        do_write(4'd5, '0, 16'h0000);
        read_check("zero_mask", 4'd2, 4'd5, '0, 1'b0, {{15{8'hAA}}, 8'h55}, 1'b1);
        read_check("unwritten", 4'd0, 4'd15, '0, 1'b0, '0, 1'b0);

        // Write and read of the same index in one cycle
        rindex_a = 4'd9;
        write    = 1'b1;
        windex   = 4'd9;
        datain   = {8{16'hDEAD}};
        wmask    = 16'hFFFF;
        #1;
`ifndef L2_PARAM_ARRAY_REG_READ_EN
        chk("old_data_pre_edge", dataout_a, '0);
        chk("old_valid_pre_edge", WIDTH'(valid_a), '0);
`endif
        tick();
        write = 1'b0;
        chk("same_cycle_data", dataout_a, {8{16'hDEAD}});
        chk("same_cycle_valid", WIDTH'(valid_a), WIDTH'(1'b1));

        // Clear: valid drops at once, write during sweep is dropped
        rindex_a = 4'd3;
        rindex_b = 4'd12;
        clear    = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_valid_a", WIDTH'(valid_a), '0);
        chk("clear_data_b", dataout_b, '0);
        chk("clear_busy", WIDTH'(busy), WIDTH'(1'b1));
        do_write(4'd7, {16{8'h77}}, 16'hFFFF);
        repeat (4) tick();
        chk("mid_sweep_busy", WIDTH'(busy), WIDTH'(1'b1));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        count_busy("restart", n);
        chk("restart_sweep_len", WIDTH'(n), WIDTH'(16));
        read_check("dropped", 4'd7, 4'd5, '0, 1'b0, '0, 1'b0);

        // Sweep zeroed the data: a partial write shows only its own byte
        do_write(4'd3, {16{8'h44}}, 16'h0002);
        read_check("post_sweep", 4'd3, 4'd9, {{14{8'h00}}, 8'h44, 8'h00}, 1'b1, '0, 1'b0);

        // Reset mid-operation clears outputs the next cycle
        rindex_a = 4'd3;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset2_data_a", dataout_a, '0);
        chk("reset2_valid_a", WIDTH'(valid_a), '0);
        count_busy("reset2", n);
        chk("reset2_sweep_len", WIDTH'(n), WIDTH'(16));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_param_array.md
# l2_param_array

Parametrised, dual-read-port, single-write-port storage array for the L2 cache data/tag path. It succeeds the fixed 16-entry array with:
- configurable width and depth;
- byte-masked writes and per-entry valid bits;
- a hardware clear sweep with a busy handshake;
- an optional registered-read mode.

Instances sit beside the L2 controller, one per way, serving a demand read port (A) and a neighbour/prefetch read port (B).

## Interface
Parameters:
- WIDTH, 128, data bits per entry; must be a multiple of 8.
- DEPTH, 16, number of entries; must be a power of two, at least 2.
- IDX_W, $clog2(DEPTH), index width (derived; do not override).

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  request to invalidate and zero the whole array.
- busy  out  1  high while a clear sweep is in progress.
- write  in  1  write strobe.
- windex  in  IDX_W  write entry.
- wmask  in  WIDTH/8  byte enables; bit k covers datain[8k+7:8k].
- datain  in  WIDTH  write data.
- rindex_a, rindex_b  in  IDX_W  read indices.
- dataout_a, dataout_b  out  WIDTH  read data.
- valid_a, valid_b  out  1  valid bit of the addressed entry.

## Operation
- **Storage:** data[DEPTH] of WIDTH bits, plus valid[DEPTH] implemented as flops.
- **FSM states:** IDLE and SWEEP; sweep pointer ptr is IDX_W bits wide.
- **reset** (highest priority), while asserted:
  - state <= SWEEP, ptr <= 0;
  - all valid bits <= 0;
  - writes are ignored.
- **clear** in IDLE or SWEEP: same effect as reset. A clear during SWEEP restarts the sweep at 0.
- **SWEEP state**, each cycle:
  - data[ptr] <= 0, ptr <= ptr+1;
  - at ptr == DEPTH-1, state <= IDLE next edge.
- **busy** = (state == SWEEP).
- **Writes:**
  - Accepted only when write=1 and busy=0 and reset=0 and clear=0. Otherwise the write is dropped silently, with no queuing.
  - An accepted write updates only the bytes whose wmask bit is 1.
  - An accepted write sets valid[windex] <= 1 if wmask != 0. A write with wmask == 0 changes nothing.
- **Reads:**
  - dataout_x = valid[rindex_x] ? data[rindex_x] : 0; valid_x = valid[rindex_x].
  - Both ports are fully independent. rindex_a == rindex_b is legal and both ports return the same value.
- **Reset values:**
  - busy = 1 (until the sweep completes);
  - valid_a = valid_b = 0;
  - dataout_a = dataout_b = 0.

## Timing
- Sweep length: busy is high for exactly DEPTH cycles after the last cycle in which reset or clear is high.
- Write-to-storage: 1 cycle. A write accepted at edge N is visible to reads from edge N onward.
- Default (combinational) read: zero latency, read-old-data. A same-cycle read of the index being written returns the pre-write value until the edge.
- Valid clearing is immediate: reads in the cycle after reset or clear return valid=0 and data 0 for every index, even entries not yet swept.
- The first write is accepted in the first cycle busy is 0.

## Configuration
- Macro: L2_PARAM_ARRAY_REG_READ_EN.
- **Defined** (registered reads):
  - dataout_x and valid_x are registered: 1-cycle latency from rindex_x.
  - Write-first bypass: if an accepted write targets the read index in the same cycle, the registered output is the merged post-write data and valid=1.
  - Output registers reset to 0. They are forced to 0 on the edge a clear is sampled.
- **Undefined:** combinational read-old-data behaviour as above.

## Test plan
- **Reset sweep:** hold reset for 3 cycles, release → busy=1 for exactly 16 cycles, then 0. All indices read valid=0, data 0 throughout.
- **Masked write:**
  - Write index 5, datain all 0xAA bytes, wmask=0xFFFF.
  - Then write index 5, datain all 0x55 bytes, wmask=0x0001.
  - Expect index 5 = 0xAAAA…AA55, valid_a=1.
- **Dual read:**
  - Write index 3 = 0x1111…, then index 12 = 0x2222….
  - Read rindex_a=3, rindex_b=12 → 0x1111…, 0x2222…, both valid.
  - Read with rindex_a = rindex_b = 12 → both ports return 0x2222….
- **Write dropped while busy:**
  - Assert clear, then write index 7 on the next cycle → write ignored.
  - After busy falls, index 7 reads valid=0, data 0.
  - Clear asserted again mid-sweep → busy extends to 16 cycles from that clear.
- **Write with zero mask:** write index 2 with wmask=0 → valid[2] stays 0, data unchanged.
- **Registered mode (L2_PARAM_ARRAY_REG_READ_EN):**
  - Write index 9 = 0xDEAD… and read rindex_a=9 in the same cycle.
  - Next cycle dataout_a=0xDEAD…, valid_a=1 (bypass).
  - Outputs are 0 the cycle after reset.
